packet_buffer_lane_allocator: RTL
=================================

# packet_buffer_lane_allocator

Packet-granular lane allocator for the packet buffer, placed between the ingress AXI-Stream parser and the NUM_LANES lane FIFOs. On the first beat of each packet it decodes `header_i.packet_length`, converts it to beats, and reserves the full packet's space in one lane chosen by least-fill or round-robin policy. It then steers every beat of that packet to the locked lane. Packets that are malformed, oversize, or whose length disagrees with `input_last_i` are dropped or truncated, and each such event is flagged.

## Interface
Parameters:
- `NUM_LANES`, 4: number of lane FIFOs (≥2).
- `DATA_WIDTH`, 64: beat width in bits, multiple of 8; `BYTES_PER_BEAT = DATA_WIDTH/8`.
- `FIFO_DEPTH`, 512: depth of each lane FIFO in beats.
- `MAX_PACKET_BYTES`, 1518: largest legal packet; `MAX_BEATS = ceil(MAX_PACKET_BYTES/BYTES_PER_BEAT)` must be ≤ `FIFO_DEPTH`.
- `SELECT_MODE`, 0: 0 = least-fill, 1 = round-robin.
- `LANE_SEL_WIDTH`, `$clog2(NUM_LANES)`: lane index width.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `header_i`, in, `packet_header_t`: header of the current beat; `packet_length` is 16-bit bytes, valid on the first beat.
- `input_valid_i`, in, 1: ingress beat valid.
- `input_last_i`, in, 1: ingress last beat of packet.
- `input_ready_o`, out, 1: ingress beat accepted.
- `lane_ready_i`, in, [NUM_LANES]: lane FIFO write side not full.
- `output_valid_i`, in, [NUM_LANES]: lane FIFO read-side valid.
- `output_ready_i`, in, [NUM_LANES]: lane FIFO read-side ready.
- `lane_sel_o`, out, `LANE_SEL_WIDTH`: lane steered this cycle.
- `lane_wr_valid_o`, out, 1: write strobe to lane `lane_sel_o`.
- `drop_o`, out, 1: one-cycle pulse, packet dropped.
- `len_err_o`, out, 1: one-cycle pulse, length/last mismatch.
- `fill_level_o`, out, [NUM_LANES][$clog2(FIFO_DEPTH+1)]: reserved-plus-occupied beats per lane.

## Operation
- States: IDLE, PASS, DROP. The state register, `lane_sel_o`, `beats_left`, `fill_level_o`, and the RR pointer are registered. `input_ready_o` and `lane_wr_valid_o` are combinational from state.
- IDLE: `input_ready_o = 0`. On `input_valid_i`, compute `beats = ceil(packet_length/BYTES_PER_BEAT)` using 17-bit arithmetic with no overflow.
  - If `beats == 0` or `packet_length > MAX_PACKET_BYTES`: go to DROP and pulse `drop_o`.
  - Otherwise a lane *fits* when `fill_level + beats ≤ FIFO_DEPTH`.
    - Least-fill: pick the lowest level among fitting lanes; ties go to the lowest index.
    - Round-robin: pick the first fitting lane starting at `rr_ptr`; afterwards `rr_ptr` = chosen + 1, mod `NUM_LANES`.
  - If a lane fits: register it in `lane_sel_o`, set `beats_left = beats`, add `beats` to that lane's level, and go to PASS.
  - If no lane fits: stay in IDLE, keep `input_ready_o = 0`, and re-evaluate every cycle. The header must be held by upstream.
- PASS:
  - `input_ready_o = lane_ready_i[lane_sel_o]`.
  - `lane_wr_valid_o = input_valid_i & lane_ready_i[lane_sel_o]`.
  - An accepted beat decrements `beats_left`.
  - Accepted beat with `input_last_i` and `beats_left == 1`: normal end, go to IDLE.
  - Accepted beat with `input_last_i` and `beats_left > 1`: pulse `len_err_o`, refund `beats_left - 1` from that lane's level, go to IDLE.
  - Accepted beat with `beats_left == 1` and no last: pulse `len_err_o`, go to DROP. No further beats are written.
- DROP: `input_ready_o = 1` and `lane_wr_valid_o = 0`. Go to IDLE on an accepted beat with `input_last_i`.
- Level update per lane per cycle: `next = level + reserve − refund − pop`, where `pop = output_valid_i & output_ready_i`. Reserve, refund, and pop on the same lane in the same cycle must all apply. Underflow is clamped at 0 and is a simulation assertion failure.
- `lane_sel_o` holds its last value outside PASS.

## Timing
- Reset (async assert, sync deassert upstream):
  - State = IDLE; all levels 0; `rr_ptr = 0`; `lane_sel_o = 0`; `beats_left = 0`.
  - `input_ready_o`, `lane_wr_valid_o`, `drop_o`, `len_err_o` = 0.
- Reset mid-packet abandons the packet and zeroes all reservations.
- Allocation latency is 1 cycle: the first beat is presented at cycle N in IDLE, and the earliest acceptance is cycle N+1 in PASS.
- Back-to-back packets have one idle cycle between the last beat and the next header's acceptance.
- A level change is visible to the allocation decision one cycle after the event.
- `drop_o` and `len_err_o` assert in the cycle after the triggering decision or beat and last exactly 1 cycle.

## Test plan
- Least-fill selection: `NUM_LANES=4`, levels preloaded {10,3,3,7}, 24-byte packet (`DATA_WIDTH=64`) → lane 1 selected; level becomes 6; 3 beats with `lane_wr_valid_o`; return to IDLE.
- Stall then admit: all levels at 510 (`FIFO_DEPTH=512`), 32-byte packet → `input_ready_o` stays 0. Pop 2 beats from lane 2 → allocate lane 2 two cycles later; lane 2 reaches 512 after the reservation.
- Round-robin: `SELECT_MODE=1`, four 8-byte packets → lanes 0,1,2,3. Fill lane 0 → the fifth packet goes to lane 1.
- Early last: 64-byte header (8 beats), `input_last_i` on beat 3 → `len_err_o` pulse; the level refund of 5 nets to +3.
- Oversize or zero length: `packet_length = 2000`, then `0` → `drop_o` pulse each, all beats accepted, `lane_wr_valid_o` never set, levels unchanged.
- Simultaneous events and reset: reserve, refund, and pop on the same lane in one cycle give the exact level; asserting `rst_ni` low mid-PASS → all outputs 0 and levels 0 immediately.

Source files
------------

// File: rtl/packet_buffer_lane_allocator.sv
// Packet-granular lane allocator: reserves a whole packet's beats in one lane FIFO on its
// first beat, steers the packet's beats to that lane, and drops or truncates bad packets.
package packet_buffer_pkg;
    typedef struct packed {
        logic [15:0] packet_length;
    } packet_header_t;
endpackage

module packet_buffer_lane_allocator
    import packet_buffer_pkg::*;
#(
    parameter int NUM_LANES        = 4,
    parameter int DATA_WIDTH       = 64,
    parameter int FIFO_DEPTH       = 512,
    parameter int MAX_PACKET_BYTES = 1518,
    parameter int SELECT_MODE      = 0,
    parameter int LANE_SEL_WIDTH   = $clog2(NUM_LANES)
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  packet_header_t                                   header_i,
    input  logic                                             input_valid_i,
    input  logic                                             input_last_i,
    output logic                                             input_ready_o,
    input  logic [NUM_LANES-1:0]                             lane_ready_i,
    input  logic [NUM_LANES-1:0]                             output_valid_i,
    input  logic [NUM_LANES-1:0]                             output_ready_i,
    output logic [LANE_SEL_WIDTH-1:0]                        lane_sel_o,
    output logic                                             lane_wr_valid_o,
    output logic                                             drop_o,
    output logic                                             len_err_o,
    output logic [NUM_LANES-1:0][$clog2(FIFO_DEPTH+1)-1:0]   fill_level_o
);
    localparam int LW             = $clog2(FIFO_DEPTH + 1);
    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam logic signed [LW+1:0] ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP} state_t;

    state_t                          r_state;
    logic [LANE_SEL_WIDTH-1:0]       r_lane_sel;
    logic [LANE_SEL_WIDTH-1:0]       r_rr_ptr;
    logic [LW-1:0]                   r_beats_left;
    logic                            r_drop;
    logic                            r_len_err;
    logic [NUM_LANES-1:0][LW-1:0]    r_level;

    logic [16:0]                     w_len17;
    logic [16:0]                     w_beats;
    logic                            w_bad;
    logic [NUM_LANES-1:0]            w_fit;
    logic                            w_found;
    logic [LANE_SEL_WIDTH-1:0]       w_pick;
    logic                            w_alloc;
    logic                            w_lane_rdy;
    logic                            w_accept;
    logic                            w_refund_en;
    logic [LW-1:0]                   w_refund_amt;
    logic signed [LW+1:0]            w_delta [NUM_LANES];
    logic [NUM_LANES-1:0]            w_underflow;
    logic [NUM_LANES-1:0][LW-1:0]    w_next_level;

    // 17-bit ceiling division so a 0xFFFF length cannot wrap to a small beat count
    assign w_len17 = {1'b0, header_i.packet_length};
    assign w_beats = (w_len17 + 17'(BYTES_PER_BEAT - 1)) / 17'(BYTES_PER_BEAT);
    assign w_bad   = (w_beats == '0) || (w_len17 > 17'(MAX_PACKET_BYTES));

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            w_fit[l] = (18'(r_level[l]) + 18'(w_beats)) <= 18'(FIFO_DEPTH);
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        if (SELECT_MODE == 1) begin
            // scan from farthest to nearest so the nearest fitting lane from rr_ptr wins
            for (int k = NUM_LANES - 1; k >= 0; k--) begin
                if (w_fit[(int'(r_rr_ptr) + k) % NUM_LANES]) begin
                    w_found = 1'b1;
                    w_pick  = LANE_SEL_WIDTH'((int'(r_rr_ptr) + k) % NUM_LANES);
                end
            end
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (w_fit[l] && (!w_found || (r_level[l] < r_level[w_pick]))) begin
                    w_found = 1'b1;
                    w_pick  = LANE_SEL_WIDTH'(l);
                end
            end
        end
    end

    assign w_lane_rdy      = lane_ready_i[r_lane_sel];
    assign input_ready_o   = (r_state == S_PASS) ? w_lane_rdy : (r_state == S_DROP);
    assign lane_wr_valid_o = (r_state == S_PASS) && input_valid_i && w_lane_rdy;
    assign w_accept        = input_valid_i && input_ready_o;
    assign w_alloc         = (r_state == S_IDLE) && input_valid_i && !w_bad && w_found;
    assign w_refund_en     = (r_state == S_PASS) && w_accept && input_last_i
                             && (r_beats_left > LW'(1));
    assign w_refund_amt    = r_beats_left - LW'(1);

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            w_delta[l] = $signed({2'b00, r_level[l]});
            if (w_alloc && (w_pick == LANE_SEL_WIDTH'(l)))
                w_delta[l] = w_delta[l] + $signed({2'b00, w_beats[LW-1:0]});
            if (w_refund_en && (r_lane_sel == LANE_SEL_WIDTH'(l)))
                w_delta[l] = w_delta[l] - $signed({2'b00, w_refund_amt});
            if (output_valid_i[l] && output_ready_i[l])
                w_delta[l] = w_delta[l] - ONE;
            w_underflow[l]  = w_delta[l] < 0;
            w_next_level[l] = w_underflow[l] ? '0 : w_delta[l][LW-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_lane_sel   <= '0;
            r_rr_ptr     <= '0;
            r_beats_left <= '0;
            r_drop       <= 1'b0;
            r_len_err    <= 1'b0;
            r_level      <= '0;
        end else begin
            r_drop    <= 1'b0;
            r_len_err <= 1'b0;
            r_level   <= w_next_level;
            case (r_state)
                S_IDLE: begin
                    if (input_valid_i) begin
                        if (w_bad) begin
                            r_state <= S_DROP;
                            r_drop  <= 1'b1;
                        end else if (w_found) begin
                            r_state      <= S_PASS;
                            r_lane_sel   <= w_pick;
                            r_beats_left <= w_beats[LW-1:0];
                            if (SELECT_MODE == 1)
                                r_rr_ptr <= (int'(w_pick) == NUM_LANES - 1) ? '0
                                            : w_pick + LANE_SEL_WIDTH'(1);
                        end
                    end
                end
                S_PASS: begin
                    if (w_accept) begin
                        r_beats_left <= r_beats_left - LW'(1);
                        if (input_last_i) begin
                            r_state <= S_IDLE;
                            if (r_beats_left > LW'(1))
                                r_len_err <= 1'b1;
                        end else if (r_beats_left == LW'(1)) begin
                            r_state   <= S_DROP;
                            r_len_err <= 1'b1;
                        end
                    end
                end
                S_DROP: begin
                    if (w_accept && input_last_i)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                assert (!w_underflow[l]);
            end
        end
    end

    assign lane_sel_o   = r_lane_sel;
    assign drop_o       = r_drop;
    assign len_err_o    = r_len_err;
    assign fill_level_o = r_level;

endmodule
